// File: rtl/stack_sequencer.sv
// stack_sequencer: multi-cycle controller for PUSH, POP, CALL and RET.
// Owns the stack pointer. Performs exactly one data-memory access per operation
// over a req/ack handshake. Returns either a popped register value or a new PC.
// The stack is full-descending: sp addresses the last pushed word, and sp == SP_TOP
// means the stack is empty.
// Optional feature macro: STACK_BOUNDS_CHECK_EN enables overflow/underflow
// detection through a one-cycle FAULT state. When it is undefined, sp simply
// wraps modulo 2^16 and fault is tied to 0.
module stack_sequencer #(
   parameter logic [15:0] SP_TOP      = 16'hFF00,
   parameter int          STACK_DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [15:0] reg_data,
   input  logic [15:0] pc_in,
   input  logic [15:0] target,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [15:0] result,
   output logic        reg_we,
   output logic        pc_load,
   output logic [15:0] pc_out,
   output logic [15:0] sp,
   output logic [2:0]  state_dbg
);

   localparam logic [1:0] OP_PUSH = 2'b00;
   localparam logic [1:0] OP_POP  = 2'b01;
   localparam logic [1:0] OP_CALL = 2'b10;
   localparam logic [1:0] OP_RET  = 2'b11;

`ifdef STACK_BOUNDS_CHECK_EN
   // sp value at which no further word may be pushed
   localparam logic [15:0] SP_FULL = SP_TOP - 16'(STACK_DEPTH);
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
`ifdef STACK_BOUNDS_CHECK_EN
      S_FIN   = 3'd3,
      S_FAULT = 3'd4
`else
      S_FIN   = 3'd3
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  op_q;
   logic [15:0] wdata_q;
   logic [15:0] target_q;
   logic [15:0] rdata_q;
   logic        op_is_write;

   // PUSH (00) and CALL (10) write memory; POP (01) and RET (11) read it
   assign op_is_write = ~op[0];
   assign state_dbg   = state_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic. start is only looked at in IDLE; WRITE/READ wait for mem_ack
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
`ifdef STACK_BOUNDS_CHECK_EN
               if (op_is_write && (sp == SP_FULL))
                  state_d = S_FAULT;
               else if (!op_is_write && (sp == SP_TOP))
                  state_d = S_FAULT;
               else
                  state_d = op_is_write ? S_WRITE : S_READ;
`else
               state_d = op_is_write ? S_WRITE : S_READ;
`endif
            end
         end
         S_WRITE: if (mem_ack) state_d = S_FIN;
         S_READ:  if (mem_ack) state_d = S_FIN;
         S_FIN:   state_d = S_IDLE;
`ifdef STACK_BOUNDS_CHECK_EN
         S_FAULT: state_d = S_IDLE;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Operand latches, read-data capture and stack pointer update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= OP_PUSH;
         wdata_q  <= 16'h0000;
         target_q <= 16'h0000;
         rdata_q  <= 16'h0000;
         sp       <= SP_TOP;
      end else begin
         if (state_q == S_IDLE && start) begin
            op_q     <= op;
            wdata_q  <= (op == OP_CALL) ? pc_in : reg_data;
            target_q <= target;
         end
         if (state_q == S_WRITE && mem_ack)
            sp <= sp - 16'd1;
         if (state_q == S_READ && mem_ack) begin
            rdata_q <= mem_rdata;
            sp      <= sp + 16'd1;
         end
      end
   end

   // Handshake: mem_req is held with stable mem_we/mem_addr/mem_wdata until the
   // cycle in which mem_ack is high. That cycle completes the transfer, and
   // mem_rdata is taken only in that cycle. mem_ack outside WRITE/READ is ignored.
   // Moore outputs decoded from the state; everything is 0 in IDLE.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 16'h0000;
      mem_wdata = 16'h0000;
      done      = 1'b0;
      fault     = 1'b0;
      result    = 16'h0000;
      reg_we    = 1'b0;
      pc_load   = 1'b0;
      pc_out    = 16'h0000;
      busy      = (state_q != S_IDLE);
      case (state_q)
         S_WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = sp - 16'd1;
            mem_wdata = wdata_q;
         end
         S_READ: begin
            mem_req  = 1'b1;
            mem_addr = sp;
         end
         S_FIN: begin
            done = 1'b1;
            case (op_q)
               OP_POP: begin
                  reg_we = 1'b1;
                  result = rdata_q;
               end
               OP_CALL: begin
                  pc_load = 1'b1;
                  pc_out  = target_q;
               end
               OP_RET: begin
                  pc_load = 1'b1;
                  pc_out  = rdata_q;
               end
               default: ;
            endcase
         end
`ifdef STACK_BOUNDS_CHECK_EN
         S_FAULT: begin
            done  = 1'b1;
            fault = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_stack_sequencer.sv
// Testbench for stack_sequencer.
// Includes a memory responder with programmable wait cycles and a stack model
// built on sp arithmetic and an associative array. It applies a table of
// directed vectors, then hand-written corner cases, then random operations.
module tb_stack_sequencer;

   localparam logic [15:0] SP_TOP = 16'hFF00;
   localparam int          DEPTH  = 256;
   localparam logic [1:0]  PUSH = 2'b00, POP = 2'b01, CALL = 2'b10, RET = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [15:0] reg_data, pc_in, target, mem_rdata;
   logic        mem_ack;
   logic        mem_req, mem_we, busy, done, fault, reg_we, pc_load;
   logic [15:0] mem_addr, mem_wdata, result, pc_out, sp;
   logic [2:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   // model state
   logic [15:0] m_sp;
   logic [15:0] ref_mem [logic [15:0]];
   logic [15:0] dev_mem [logic [15:0]];
   logic [15:0] exp_q [$];

   typedef struct {
      logic [1:0]  op;
      logic [15:0] rd, pc, tgt;
      int          waits;
      logic [15:0] e_res, e_pc, e_sp;
   } vec_t;
   vec_t vecs [4];

   stack_sequencer #(.SP_TOP(SP_TOP), .STACK_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .reg_data(reg_data),
      .pc_in(pc_in), .target(target), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .busy(busy), .done(done), .fault(fault),
      .result(result), .reg_we(reg_we), .pc_load(pc_load), .pc_out(pc_out),
      .sp(sp), .state_dbg(state_dbg)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors + 1);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [15:0] dflt(input logic [15:0] a);
      return a ^ 16'h5A5A;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One complete operation: model prediction, drive start, serve memory, check outcome
   task automatic run_op(input logic [1:0] o, input logic [15:0] rd, input logic [15:0] pc,
                         input logic [15:0] tgt, input int waits, input bit poke,
                         output logic [15:0] r_res, output logic [15:0] r_pc,
                         output logic [15:0] r_sp);
      logic        is_wr, fexp;
      logic [15:0] eaddr, ewdata, epc, erd;
      int          cyc, wcnt;
      bit          seen_done, seen_req;
      is_wr  = (o == PUSH) || (o == CALL);
      fexp   = 1'b0;
`ifdef STACK_BOUNDS_CHECK_EN
      fexp = is_wr ? (m_sp == SP_TOP - 16'(DEPTH)) : (m_sp == SP_TOP);
`endif
      eaddr = 16'h0; ewdata = 16'h0; epc = 16'h0; erd = 16'h0;
      if (!fexp) begin
         if (is_wr) begin
            eaddr  = m_sp - 16'd1;
            ewdata = (o == PUSH) ? rd : pc;
            ref_mem[eaddr] = ewdata;
            m_sp = m_sp - 16'd1;
            if (o == CALL) epc = tgt;
         end else begin
            eaddr = m_sp;
            erd   = ref_mem.exists(eaddr) ? ref_mem[eaddr] : dflt(eaddr);
            exp_q.push_back(erd);
            m_sp = m_sp + 16'd1;
         end
      end
      @(negedge clk);
      start = 1'b1; op = o; reg_data = rd; pc_in = pc; target = tgt;
      @(negedge clk);
      start = 1'b0;
      reg_data = 16'($urandom); pc_in = 16'($urandom); target = 16'($urandom);
      cyc = 2; wcnt = 0; seen_done = 1'b0; seen_req = 1'b0;
      r_res = 16'h0; r_pc = 16'h0; r_sp = 16'h0;
      while (!seen_done && cyc < 60) begin
         if (done) begin
            seen_done = 1'b1;
         end else begin
            if (poke && cyc == 2) begin
               start = 1'b1; op = POP;
            end else begin
               start = 1'b0;
            end
            if (mem_req) begin
               seen_req = 1'b1;
               check("mem_addr", mem_addr, eaddr);
               check("mem_we", {15'h0, mem_we}, {15'h0, is_wr});
               if (is_wr) check("mem_wdata", mem_wdata, ewdata);
               if (wcnt == waits) begin
                  mem_ack = 1'b1;
                  if (mem_we) dev_mem[mem_addr] = mem_wdata;
                  else mem_rdata = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : dflt(mem_addr);
               end else begin
                  wcnt++;
               end
            end
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = 16'($urandom);
            cyc++;
         end
      end
      checks++;
      if (!seen_done) begin
         errors++;
         $display("FAIL done_timeout: no done after %0d cycles for op %0d", cyc, o);
      end else begin
         r_res = result; r_pc = pc_out; r_sp = sp;
         check("latency", 16'(cyc), fexp ? 16'd2 : 16'(3 + waits));
         check("fault", {15'h0, fault}, {15'h0, fexp});
         check("mem_req_seen", {15'h0, seen_req}, {15'h0, ~fexp});
         check("reg_we", {15'h0, reg_we}, {15'h0, (o == POP) && !fexp});
         check("pc_load", {15'h0, pc_load}, {15'h0, (o[1] == 1'b1) && !fexp});
         check("busy_fin", {15'h0, busy}, 16'h1);
         check("sp", sp, m_sp);
         if (!fexp && !is_wr) begin
            erd = exp_q.pop_front();
            if (o == POP) check("result", result, erd);
            else check("pc_out_ret", pc_out, erd);
         end
         if (!fexp && o == CALL) check("pc_out_call", pc_out, epc);
      end
      @(negedge clk);
      start = 1'b0;
      check("done_pulse", {15'h0, done}, 16'h0);
      check("busy_after", {15'h0, busy}, 16'h0);
      if (poke) begin
         @(negedge clk);
         check("poke_no_second_op", {15'h0, busy}, 16'h0);
      end
   endtask

   initial begin
      logic [15:0] r_res, r_pc, r_sp;
      vecs[0] = '{PUSH, 16'h1234, 16'h0000, 16'h0000, 2, 16'h0000, 16'h0000, 16'hFEFF};
      vecs[1] = '{POP,  16'h0000, 16'h0000, 16'h0000, 0, 16'h1234, 16'h0000, 16'hFF00};
      vecs[2] = '{CALL, 16'h0000, 16'h0041, 16'h0200, 1, 16'h0000, 16'h0200, 16'hFEFF};
      vecs[3] = '{RET,  16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0041, 16'hFF00};

      // reset
      rst = 1'b1; start = 1'b0; op = PUSH; reg_data = 16'h0; pc_in = 16'h0;
      target = 16'h0; mem_rdata = 16'h0; mem_ack = 1'b0; m_sp = SP_TOP;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_sp", sp, 16'hFF00);
      check("rst_busy", {15'h0, busy}, 16'h0);
      check("rst_mem_req", {15'h0, mem_req}, 16'h0);
      check("rst_done", {15'h0, done}, 16'h0);
      check("rst_result", result, 16'h0);
      check("rst_pc_out", pc_out, 16'h0);

      // ack while idle must be ignored
      @(negedge clk); mem_ack = 1'b1;
      @(negedge clk); mem_ack = 1'b0;
      check("idle_ack_sp", sp, SP_TOP);
      check("idle_ack_busy", {15'h0, busy}, 16'h0);

      // directed vector table
      for (int i = 0; i < 4; i++) begin
         run_op(vecs[i].op, vecs[i].rd, vecs[i].pc, vecs[i].tgt, vecs[i].waits, 1'b0,
                r_res, r_pc, r_sp);
         check($sformatf("vec%0d_sp", i), r_sp, vecs[i].e_sp);
         if (vecs[i].op == POP) check($sformatf("vec%0d_res", i), r_res, vecs[i].e_res);
         if (vecs[i].op[1]) check($sformatf("vec%0d_pc", i), r_pc, vecs[i].e_pc);
      end

      // busy handling: POP start during WRITE is ignored
      run_op(PUSH, 16'h7777, 16'h0, 16'h0, 2, 1'b1, r_res, r_pc, r_sp);
      check("poke_sp", r_sp, 16'hFEFF);

      // asynchronous reset in the middle of a write
      @(negedge clk);
      start = 1'b1; op = PUSH; reg_data = 16'hDEAD;
      @(negedge clk);
      start = 1'b0;
      check("pre_rst_req", {15'h0, mem_req}, 16'h1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_sp", sp, 16'hFF00);
      check("mid_rst_busy", {15'h0, busy}, 16'h0);
      check("mid_rst_req", {15'h0, mem_req}, 16'h0);
      @(negedge clk);
      rst = 1'b0;
      m_sp = SP_TOP;
      check("post_rst_sp", sp, 16'hFF00);

`ifdef STACK_BOUNDS_CHECK_EN
      // underflow, then fill to capacity and overflow
      run_op(POP, 16'h0, 16'h0, 16'h0, 0, 1'b0, r_res, r_pc, r_sp);
      check("underflow_sp", r_sp, 16'hFF00);
      for (int i = 0; i < DEPTH; i++)
         run_op(PUSH, 16'(i), 16'h0, 16'h0, 0, 1'b0, r_res, r_pc, r_sp);
      check("full_sp", sp, 16'hFE00);
      run_op(PUSH, 16'hBAD0, 16'h0, 16'h0, 0, 1'b0, r_res, r_pc, r_sp);
      check("overflow_sp", r_sp, 16'hFE00);
`else
      // no bounds check: POP from the empty stack reads SP_TOP and wraps upward
      run_op(POP, 16'h0, 16'h0, 16'h0, 1, 1'b0, r_res, r_pc, r_sp);
      check("nobound_res", r_res, dflt(16'hFF00));
      check("nobound_sp", r_sp, 16'hFF01);
`endif

      // randomized operations against the model
      for (int i = 0; i < 150; i++)
         run_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 16'($urandom),
                $urandom_range(0, 3), 1'b0, r_res, r_pc, r_sp);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
